// File: rtl/serial_comparator_pkg.sv
// Shared encodings for the serial comparator family.
// States and decisions used by bit-serial compare blocks.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    DEC_UNDEC = 2'd0,
    DEC_A_GT  = 2'd1,
    DEC_B_GT  = 2'd2
  } dec_e;

  function automatic dec_e next_dec(
    input dec_e d,
    input logic a,
    input logic b
  );
    if (d == DEC_UNDEC && a != b)
      return a ? DEC_A_GT : DEC_B_GT;
    return d;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// Control, bit stream and result bundle
// of the bit-serial comparator.
interface serial_comparator_if;
  logic start;
  logic abort;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic a_grt;
  logic b_grt;
  logic a_eq_b;

  modport master (
    output start, abort, bit_valid,
    output a_bit, b_bit,
    input  busy, done,
    input  a_grt, b_grt, a_eq_b
  );

  modport slave (
    input  start, abort, bit_valid,
    input  a_bit, b_bit,
    output busy, done,
    output a_grt, b_grt, a_eq_b
  );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator, MSB first.
// Result flags are registered and held until the next done.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  serial_comparator_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e          state_q;
  dec_e            dec_q;
  dec_e            dec_d;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic            agt_q;
  logic            bgt_q;
  logic            eq_q;

  always_comb begin
    dec_d = next_dec(dec_q, bus.a_bit, bus.b_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dec_q   <= DEC_UNDEC;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      agt_q   <= 1'b0;
      bgt_q   <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (bus.start) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              dec_q   <= DEC_UNDEC;
            end
          end
          ST_SHIFT: begin
            if (bus.bit_valid) begin
              cnt_q <= cnt_q + 1'b1;
              dec_q <= dec_d;
              // Flags take the decision including the final pair
              if (cnt_q == LAST) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                agt_q   <= (dec_d == DEC_A_GT);
                bgt_q   <= (dec_d == DEC_B_GT);
                eq_q    <= (dec_d == DEC_UNDEC);
              end
            end
          end
          ST_DONE: begin
            if (bus.start) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
              cnt_q   <= '0;
              dec_q   <= DEC_UNDEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.a_grt  = agt_q;
  assign bus.b_grt  = bgt_q;
  assign bus.a_eq_b = eq_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator at WIDTH=2 and WIDTH=8
// against a value-level model of the operands.
module tb_serial_comparator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic st [2];
  logic ab [2];
  logic vl [2];
  logic ai [2];
  logic bi [2];
  logic [4:0] got [2];

  serial_comparator_if i0 ();
  serial_comparator_if i1 ();

  assign i0.start     = st[0];
  assign i0.abort     = ab[0];
  assign i0.bit_valid = vl[0];
  assign i0.a_bit     = ai[0];
  assign i0.b_bit     = bi[0];
  assign i1.start     = st[1];
  assign i1.abort     = ab[1];
  assign i1.bit_valid = vl[1];
  assign i1.a_bit     = ai[1];
  assign i1.b_bit     = bi[1];

  assign got[0] = {i0.busy, i0.done, i0.a_grt, i0.b_grt, i0.a_eq_b};
  assign got[1] = {i1.busy, i1.done, i1.a_grt, i1.b_grt, i1.a_eq_b};

  serial_comparator #(.WIDTH(2)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i0.slave)
  );

  serial_comparator #(.WIDTH(8)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i1.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: collect operand values, compare them as integers at the end.
  int         md [2];
  int         cn [2];
  logic [7:0] av [2];
  logic [7:0] bv [2];
  logic [4:0] ex [2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        md[k] = 0;
        cn[k] = 0;
        av[k] = 8'd0;
        bv[k] = 8'd0;
        ex[k] = 5'd0;
      end else begin
        ex[k][3] = 1'b0;
        if (ab[k]) begin
          md[k] = 0;
        end else if (md[k] == 1) begin
          if (vl[k]) begin
            av[k] = {av[k][6:0], ai[k]};
            bv[k] = {bv[k][6:0], bi[k]};
            cn[k]++;
            if (cn[k] == ((k == 0) ? 2 : 8)) begin
              md[k] = 2;
              ex[k][3] = 1'b1;
              ex[k][2] = av[k] > bv[k];
              ex[k][1] = av[k] < bv[k];
              ex[k][0] = av[k] == bv[k];
            end
          end
        end else if (st[k]) begin
          md[k] = 1;
          cn[k] = 0;
          av[k] = 8'd0;
          bv[k] = 8'd0;
        end else begin
          md[k] = 0;
        end
        ex[k][4] = (md[k] == 1);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_u0", 32'(got[0]), 32'(ex[0]));
      chk("model_u1", 32'(got[1]), 32'(ex[1]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cmp(int k, int w, logic [7:0] a, logic [7:0] b);
    st[k] = 1'b1;
    tick();
    st[k] = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      vl[k] = 1'b1;
      ai[k] = a[i];
      bi[k] = b[i];
      tick();
    end
    vl[k] = 1'b0;
    chk("done_at_lat", 32'(got[k][3]), 32'd1);
    tick();
    chk("done_one_cyc", 32'(got[k][3]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0;
      ab[k] = 1'b0;
      vl[k] = 1'b0;
      ai[k] = 1'b0;
      bi[k] = 1'b0;
    end
    repeat (2) tick();
    chk("reset_u0", 32'(got[0]), 32'd0);
    chk("reset_u1", 32'(got[1]), 32'd0);
    rst_n = 1'b1;
    tick();

    cmp(0, 2, 8'd2, 8'd1);
    chk("a10_b01", 32'(got[0][2:0]), 32'b100);

    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        cmp(0, 2, 8'(a), 8'(b));
    cmp(0, 2, 8'd1, 8'd3);
    chk("a01_b11", 32'(got[0][2:0]), 32'b010);
    cmp(0, 2, 8'd3, 8'd3);
    chk("a11_b11", 32'(got[0][2:0]), 32'b001);

    // Reset in the middle of a comparison
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    vl[0] = 1'b1;
    ai[0] = 1'b1;
    bi[0] = 1'b0;
    tick();
    vl[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_mid", 32'(got[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    vl[0] = 1'b1;
    ai[0] = 1'b1;
    bi[0] = 1'b0;
    repeat (4) tick();
    vl[0] = 1'b0;
    chk("idle_valid", 32'(got[0]), 32'd0);

    // Stall between the two bits
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    vl[0] = 1'b1;
    ai[0] = 1'b0;
    bi[0] = 1'b0;
    tick();
    vl[0] = 1'b0;
    repeat (3) begin
      chk("stall_busy", 32'(got[0][4]), 32'd1);
      tick();
    end
    vl[0] = 1'b1;
    ai[0] = 1'b1;
    bi[0] = 1'b0;
    tick();
    vl[0] = 1'b0;
    chk("stall_done", 32'(got[0]), 32'b01100);
    tick();

    // Back-to-back with start held high throughout
    st[0] = 1'b1;
    tick();
    vl[0] = 1'b1;
    ai[0] = 1'b0;
    bi[0] = 1'b0;
    tick();
    ai[0] = 1'b0;
    bi[0] = 1'b1;
    tick();
    chk("b2b_first", 32'(got[0]), 32'b01010);
    ai[0] = 1'b1;
    bi[0] = 1'b1;
    tick();
    chk("b2b_restart", 32'(got[0]), 32'b10010);
    tick();
    ai[0] = 1'b1;
    bi[0] = 1'b0;
    tick();
    chk("b2b_second", 32'(got[0]), 32'b01100);
    st[0] = 1'b0;
    vl[0] = 1'b0;
    tick();

    // Abort after the first pair
    st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    vl[0] = 1'b1;
    ai[0] = 1'b1;
    bi[0] = 1'b0;
    tick();
    vl[0] = 1'b0;
    ab[0] = 1'b1;
    tick();
    ab[0] = 1'b0;
    chk("abort_busy", 32'(got[0]), 32'b00100);
    vl[0] = 1'b1;
    repeat (3) tick();
    vl[0] = 1'b0;
    chk("abort_hold", 32'(got[0]), 32'b00100);
    cmp(0, 2, 8'd0, 8'd3);
    chk("after_abort", 32'(got[0][2:0]), 32'b010);

    cmp(1, 8, 8'h80, 8'h7f);
    chk("w8_80_7f", 32'(got[1][2:0]), 32'b100);
    cmp(1, 8, 8'h5a, 8'h5a);
    chk("w8_5a_5a", 32'(got[1][2:0]), 32'b001);
    cmp(1, 8, 8'h3c, 8'h3d);
    chk("w8_3c_3d", 32'(got[1][2:0]), 32'b010);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
